// File: rtl/alu_issue_if.sv
// Issue-stage bus for alu_issue: instruction beat in, decoded ALU beat out.
interface alu_issue_if #(
    parameter int BITS        = 32,
    parameter int OPTION_BITS = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            instr;
    logic [BITS-1:0]        rs_data;
    logic [BITS-1:0]        rt_data;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [OPTION_BITS-1:0] alu_select;
    logic [BITS-1:0]        alu_a;
    logic [BITS-1:0]        alu_b;
    logic [4:0]             dest_reg;
    logic                   reg_write;
    logic                   mem_read;
    logic                   mem_write;
    logic                   illegal;
    logic [BITS-1:0]        store_data;
    logic [7:0]             illegal_count;

    modport master (
        output in_valid, instr, rs_data, rt_data, flush, out_ready,
        input  in_ready, out_valid, alu_select, alu_a, alu_b, dest_reg,
               reg_write, mem_read, mem_write, illegal, store_data, illegal_count
    );

    modport slave (
        input  in_valid, instr, rs_data, rt_data, flush, out_ready,
        output in_ready, out_valid, alu_select, alu_a, alu_b, dest_reg,
               reg_write, mem_read, mem_write, illegal, store_data, illegal_count
    );
endinterface

// File: rtl/alu_issue.sv
// MIPS decode/issue stage with a single-entry output register toward the ALU.
// Define ALU_ISSUE_MUL_EN to decode opcode 0x1C funct 0x02 (mul) instead of flagging it illegal.
module alu_issue #(
    parameter int BITS        = 32,
    parameter int OPTION_BITS = 8
) (
    input logic         clk,
    input logic         rstn,
    alu_issue_if.slave  bus
);
    typedef struct packed {
        logic [OPTION_BITS-1:0] alu_select;
        logic [BITS-1:0]        alu_a;
        logic [BITS-1:0]        alu_b;
        logic [4:0]             dest_reg;
        logic                   reg_write;
        logic                   mem_read;
        logic                   mem_write;
        logic                   illegal;
        logic [BITS-1:0]        store_data;
    } beat_t;

    beat_t           dec;
    beat_t           beat_d, beat_q;
    logic            out_valid_d, out_valid_q;
    logic [7:0]      illegal_count_d, illegal_count_q;
    logic            accept;
    logic [5:0]      opcode, funct;
    logic [4:0]      rt, rd;
    logic [BITS-1:0] imm_sext, imm_zext;

    assign opcode   = bus.instr[31:26];
    assign funct    = bus.instr[5:0];
    assign rt       = bus.instr[20:16];
    assign rd       = bus.instr[15:11];
    assign imm_sext = {{(BITS-16){bus.instr[15]}}, bus.instr[15:0]};
    assign imm_zext = {{(BITS-16){1'b0}}, bus.instr[15:0]};

    // Immediate-form select codes equal the opcode, so they are reused directly.
    always_comb begin
        dec       = '0;
        dec.alu_a = bus.rs_data;
        case (opcode)
            6'h00: begin
                if (bus.instr != 32'h0) begin
                    if (funct inside {6'h20, 6'h22, 6'h24, 6'h25}) begin
                        dec.alu_select = OPTION_BITS'(funct);
                        dec.alu_b      = bus.rt_data;
                        dec.dest_reg   = rd;
                        dec.reg_write  = 1'b1;
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end
            end
            6'h08, 6'h23: begin
                dec.alu_select = OPTION_BITS'(opcode);
                dec.alu_b      = imm_sext;
                dec.dest_reg   = rt;
                dec.reg_write  = 1'b1;
                dec.mem_read   = (opcode == 6'h23);
            end
            6'h0D: begin
                dec.alu_select = OPTION_BITS'(opcode);
                dec.alu_b      = imm_zext;
                dec.dest_reg   = rt;
                dec.reg_write  = 1'b1;
            end
            6'h2B: begin
                dec.alu_select = OPTION_BITS'(opcode);
                dec.alu_b      = imm_sext;
                dec.mem_write  = 1'b1;
                dec.store_data = bus.rt_data;
            end
`ifdef ALU_ISSUE_MUL_EN
            6'h1C: begin
                if (funct == 6'h02) begin
                    dec.alu_select = OPTION_BITS'(8'h3A);
                    dec.alu_b      = bus.rt_data;
                    dec.dest_reg   = rd;
                    dec.reg_write  = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
`endif
            default: dec.illegal = 1'b1;
        endcase
        // $zero is never written.
        if (dec.dest_reg == 5'd0) dec.reg_write = 1'b0;
    end

    assign bus.in_ready = rstn && !bus.flush && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        out_valid_d     = out_valid_q;
        beat_d          = beat_q;
        illegal_count_d = illegal_count_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            beat_d      = dec;
            if (dec.illegal && illegal_count_q != 8'hFF)
                illegal_count_d = illegal_count_q + 8'd1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_q     <= 1'b0;
            beat_q          <= '0;
            illegal_count_q <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            beat_q          <= beat_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.alu_select    = beat_q.alu_select;
    assign bus.alu_a         = beat_q.alu_a;
    assign bus.alu_b         = beat_q.alu_b;
    assign bus.dest_reg      = beat_q.dest_reg;
    assign bus.reg_write     = beat_q.reg_write;
    assign bus.mem_read      = beat_q.mem_read;
    assign bus.mem_write     = beat_q.mem_write;
    assign bus.illegal       = beat_q.illegal;
    assign bus.store_data    = beat_q.store_data;
    assign bus.illegal_count = illegal_count_q;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: per-cycle comparison against a behavioural model plus literal spot checks.
module tb_alu_issue;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    alu_issue_if #(.BITS(32), .OPTION_BITS(8)) bif ();
    alu_issue dut (.clk(clk), .rstn(rstn), .bus(bif));

`ifdef ALU_ISSUE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        rw, mr, mw, ill;
        logic [31:0] sd;
    } m_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   armed = 1'b0;
    bit   ev    = 1'b0;
    m_t   em    = '0;
    int   ecnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected decode straight from the instruction-set rules.
    function automatic m_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rtv);
        m_t r;
        logic [5:0] op, fn;
        r = '0;
        r.a = rs;
        op = ins[31:26];
        fn = ins[5:0];
        if (ins == 32'h0) begin
        end else if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25)) begin
            r.sel = {2'b00, fn}; r.b = rtv; r.dest = ins[15:11]; r.rw = 1'b1;
        end else if (op == 6'h08 || op == 6'h23) begin
            r.sel = {2'b00, op}; r.b = {{16{ins[15]}}, ins[15:0]}; r.dest = ins[20:16];
            r.rw = 1'b1; r.mr = (op == 6'h23);
        end else if (op == 6'h0D) begin
            r.sel = 8'h0D; r.b = {16'h0, ins[15:0]}; r.dest = ins[20:16]; r.rw = 1'b1;
        end else if (op == 6'h2B) begin
            r.sel = 8'h2B; r.b = {{16{ins[15]}}, ins[15:0]}; r.mw = 1'b1; r.sd = rtv;
        end else if (MUL_EN && op == 6'h1C && fn == 6'h02) begin
            r.sel = 8'h3A; r.b = rtv; r.dest = ins[15:11]; r.rw = 1'b1;
        end else begin
            r.ill = 1'b1;
        end
        if (r.dest == 5'd0) r.rw = 1'b0;
        return r;
    endfunction

    always @(posedge clk) begin
        bit rdy;
        rdy = rstn && !bif.flush && (!ev || bif.out_ready);
        if (!rstn) begin
            armed = 1'b1; ev = 1'b0; em = '0; ecnt = 0;
        end else if (bif.flush) begin
            ev = 1'b0;
        end else if (bif.in_valid && rdy) begin
            ev = 1'b1;
            em = model(bif.instr, bif.rs_data, bif.rt_data);
            if (em.ill && ecnt < 255) ecnt++;
        end else if (bif.out_ready) begin
            ev = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("out_valid", bif.out_valid, ev);
            chk("in_ready", bif.in_ready, rstn && !bif.flush && (!ev || bif.out_ready));
            chk("illegal_count", bif.illegal_count, ecnt);
            chk("alu_select", bif.alu_select, em.sel);
            chk("alu_a", bif.alu_a, em.a);
            chk("alu_b", bif.alu_b, em.b);
            chk("dest_reg", bif.dest_reg, em.dest);
            chk("reg_write", bif.reg_write, em.rw);
            chk("mem_read", bif.mem_read, em.mr);
            chk("mem_write", bif.mem_write, em.mw);
            chk("illegal", bif.illegal, em.ill);
            chk("store_data", bif.store_data, em.sd);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    logic [31:0] rtype [3];

    initial begin
        rtype[0] = 32'h00851022; rtype[1] = 32'h00851024; rtype[2] = 32'h00851025;
        rstn = 1'b0;
        bif.in_valid = 1'b0; bif.instr = '0; bif.rs_data = '0; bif.rt_data = '0;
        bif.flush = 1'b0; bif.out_ready = 1'b0;
        tick(); tick();
        chk("rst_out_valid", bif.out_valid, 1'b0);
        chk("rst_in_ready", bif.in_ready, 1'b0);
        chk("rst_count", bif.illegal_count, 8'h00);
        rstn = 1'b1;
        #1 chk("release_in_ready", bif.in_ready, 1'b1);

        // add $2,$4,$5
        bif.instr = 32'h00851020; bif.rs_data = 7; bif.rt_data = 5;
        bif.in_valid = 1'b1; bif.out_ready = 1'b1;
        tick();
        chk("add_valid", bif.out_valid, 1'b1);
        chk("add_sel", bif.alu_select, 8'h20);
        chk("add_a", bif.alu_a, 32'd7);
        chk("add_b", bif.alu_b, 32'd5);
        chk("add_dest", bif.dest_reg, 5'd2);
        chk("add_rw", bif.reg_write, 1'b1);

        bif.instr = 32'h2082FFFF; tick();
        chk("addi_b", bif.alu_b, 32'hFFFFFFFF);
        bif.instr = 32'h3482FFFF; tick();
        chk("ori_b", bif.alu_b, 32'h0000FFFF);
        for (int i = 0; i < 3; i++) begin
            bif.instr = rtype[i]; tick();
        end
        bif.instr = 32'h00850020; tick();
        chk("dest0_rw", bif.reg_write, 1'b0);
        bif.instr = 32'h8C820008; bif.rs_data = 32'h100; tick();
        chk("lw_mr", bif.mem_read, 1'b1);
        bif.instr = 32'h00000000; tick();
        chk("nop_ill", bif.illegal, 1'b0);
        bif.instr = 32'h0085102A; tick();
        chk("bad_funct_ill", bif.illegal, 1'b1);

        // SW held under back-pressure while a new beat waits
        bif.instr = 32'hAC850004; bif.rs_data = 4; bif.rt_data = 32'h55; tick();
        bif.out_ready = 1'b0; bif.instr = 32'h00851020; bif.rt_data = 32'h99;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_in_ready", bif.in_ready, 1'b0);
            chk("hold_mw", bif.mem_write, 1'b1);
            chk("hold_sd", bif.store_data, 32'h55);
            tick();
        end
        bif.out_ready = 1'b1; tick();
        chk("replace_sel", bif.alu_select, 8'h20);
        chk("replace_b", bif.alu_b, 32'h99);

        // flush drops the offered beat
        bif.flush = 1'b1; bif.instr = 32'h3482FFFF;
        #1 chk("flush_in_ready", bif.in_ready, 1'b0);
        tick();
        chk("flush_valid", bif.out_valid, 1'b0);
        bif.flush = 1'b0; bif.in_valid = 1'b0; tick();
        chk("flush_dropped", bif.out_valid, 1'b0);

        bif.in_valid = 1'b1; bif.instr = 32'h70851002; bif.rt_data = 3; tick();
        chk("mul_sel", bif.alu_select, MUL_EN ? 8'h3A : 8'h00);
        chk("mul_ill", bif.illegal, !MUL_EN);

        bif.instr = 32'hFC000000;
        repeat (260) tick();
        chk("sat_count", bif.illegal_count, 8'hFF);
        bif.in_valid = 1'b0; rstn = 1'b0; tick();
        chk("rst2_count", bif.illegal_count, 8'h00);
        chk("rst2_valid", bif.out_valid, 1'b0);
        chk("rst2_ready", bif.in_ready, 1'b0);
        rstn = 1'b1; tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter BITS, default 32, datapath width.
REQ-002 SHALL have parameter OPTION_BITS, default 8, width of alu_select.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rstn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  instruction beat offered.
REQ-006 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-007 SHALL have port instr  input  32  MIPS instruction word.
REQ-008 SHALL have port rs_data  input  BITS  register-file value for rs.
REQ-009 SHALL have port rt_data  input  BITS  register-file value for rt.
REQ-010 SHALL have port flush  input  1  discard held beat.
REQ-011 SHALL have port out_valid  output  1  decoded beat valid toward the ALU stage.
REQ-012 SHALL have port out_ready  input  1  ALU stage accepts the beat.
REQ-013 SHALL have port alu_select, alu_a, alu_b  output  OPTION_BITS/BITS/BITS  ALU operation and operands.
REQ-014 SHALL have port dest_reg  output  5; reg_write, mem_read, mem_write, illegal  output  1 each; store_data  output  BITS.
REQ-015 SHALL have port illegal_count  output  8  saturating count of illegal beats accepted.

Function
REQ-016 SHALL be a single-entry output register: in_ready = !flush && (!out_valid || out_ready); latency from acceptance to out_valid is 1 cycle.
REQ-017 On acceptance, SHALL register decoded fields and set out_valid=1; on out_ready with no acceptance, SHALL clear out_valid; held outputs SHALL remain stable while out_valid && !out_ready.
REQ-018 Simultaneous out_ready and acceptance SHALL replace the beat with no bubble (full throughput).
REQ-019 flush SHALL clear out_valid next cycle, take priority over acceptance, and drop any in_valid presented that cycle (in_ready=0).
REQ-020 alu_a SHALL always be rs_data.
REQ-021 opcode 0x00, funct 0x20/0x22/0x24/0x25: alu_select=funct (zero-extended), alu_b=rt_data, dest_reg=rd, reg_write=1.
REQ-022 opcode 0x08 (ADDI): alu_select=0x08, alu_b=sign-extended imm16, dest_reg=rt, reg_write=1.
REQ-023 opcode 0x0D (ORI): alu_select=0x0D, alu_b=zero-extended imm16, dest_reg=rt, reg_write=1.
REQ-024 opcode 0x23 (LW): alu_select=0x23, alu_b=sign-extended imm16, dest_reg=rt, reg_write=1, mem_read=1.
REQ-025 opcode 0x2B (SW): alu_select=0x2B, alu_b=sign-extended imm16, store_data=rt_data, mem_write=1, reg_write=0.
REQ-026 instr==0 (NOP): alu_select=0, all control flags 0, illegal=0.
REQ-027 Any other encoding: alu_select=0, reg_write=mem_read=mem_write=0, illegal=1, illegal_count increments once per accepted beat, saturating at 0xFF.
REQ-028 reg_write SHALL be forced 0 when dest_reg==0.
REQ-029 store_data SHALL be 0 for every non-SW beat.

Reset
REQ-030 With rstn=0 at a clock edge: out_valid=0, all output fields 0, illegal_count=0; held beat discarded mid-transfer.
REQ-031 in_ready SHALL be 0 during reset and follow REQ-016 from the first cycle after release.

Configuration
REQ-032 Macro ALU_ISSUE_MUL_EN defined: opcode 0x1C funct 0x02 SHALL decode to alu_select=0x3A, alu_b=rt_data, dest_reg=rd, reg_write=1.
REQ-033 Macro ALU_ISSUE_MUL_EN undefined: that encoding SHALL be treated as illegal per REQ-027.

Verification
REQ-034 instr=0x00851020 (add $2,$4,$5), rs=7, rt=5, out_ready=1 -> next cycle out_valid=1, select=0x20, a=7, b=5, dest=2, reg_write=1.
REQ-035 instr=0x2082FFFF (addi $2,$4,-1) -> b=0xFFFFFFFF; instr=0x3482FFFF (ori) -> b=0x0000FFFF.
REQ-036 Accept SW 0xAC850004, hold out_ready=0 3 cycles with in_valid=1 -> in_ready=0, outputs stable, mem_write=1, store_data=rt_data; then out_ready=1 -> next beat loaded same edge.
REQ-037 flush=1 with out_valid=1 and in_valid=1 -> in_ready=0, out_valid=0 next cycle, dropped beat never appears.
REQ-038 260 accepted beats of 0xFC000000 -> illegal=1 each, illegal_count=0xFF; rstn=0 one cycle -> count=0, out_valid=0.
REQ-039 instr=0x70851002 (mul) -> select=0x3A with ALU_ISSUE_MUL_EN; illegal=1, select=0 without.
